scratchpad_backdoor_responder: RTL and testbench

SCRATCHPAD_BACKDOOR_RESPONDER -- requirements
Module: scratchpad_backdoor_responder

---
 rtl/scratchpad_backdoor_responder.sv | 127 ++++++++++++
 tb/tb_scratchpad_backdoor_responder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/scratchpad_backdoor_responder.sv
// Scratchpad backdoor responder: arbitrates a 32-bit byte-addressed backdoor
// channel against a word-indexed functional port onto a single SRAM port.
module scratchpad_backdoor_responder #(
  parameter logic [31:0] BASE_ADDR    = 32'h6400_0000,
  parameter int unsigned MEM_BYTES    = 65536,
  parameter int unsigned STARVE_LIMIT = 8,
  localparam int unsigned AW          = $clog2(MEM_BYTES / 8)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          bd_req_valid,
  output logic          bd_req_ready,
  input  logic          bd_req_write,
  input  logic [31:0]   bd_req_addr,
  input  logic [63:0]   bd_req_wdata,
  output logic          bd_rsp_valid,
  input  logic          bd_rsp_ready,
  output logic [63:0]   bd_rsp_rdata,
  output logic          bd_rsp_err,
  input  logic          fn_valid,
  output logic          fn_ready,
  input  logic          fn_write,
  input  logic [AW-1:0] fn_addr,
  input  logic [63:0]   fn_wdata,
  input  logic [7:0]    fn_mask,
  output logic          fn_rsp_valid,
  output logic [63:0]   fn_rdata,
  output logic          mem_req,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [63:0]   mem_wdata,
  output logic [7:0]    mem_mask,
  input  logic [63:0]   mem_rdata
);

  localparam int unsigned SW       = $clog2(STARVE_LIMIT + 1);
  localparam logic [32:0] END_ADDR = 33'(BASE_ADDR) + 33'(MEM_BYTES);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RSP} state_t;

  state_t          state, state_d;
  logic [SW-1:0]   starve_cnt, starve_d;
  logic [63:0]     rdata_d;
  logic            err_d;
  logic            in_range;
  logic            bd_mem;
  logic            fn_acc;

  assign in_range = (bd_req_addr >= BASE_ADDR) && ({1'b0, bd_req_addr} < END_ADDR)
                    && (bd_req_addr[2:0] == 3'b000);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Arbitration, FSM next state, SRAM port mux; reset gates every handshake.
  always_comb begin
    state_d      = state;
    starve_d     = starve_cnt;
    rdata_d      = bd_rsp_rdata;
    err_d        = bd_rsp_err;
    bd_req_ready = 1'b0;
    bd_mem       = 1'b0;
    unique case (state)
      IDLE: begin
        bd_req_ready = !rst && bd_req_valid
                       && (!fn_valid || starve_cnt == SW'(STARVE_LIMIT));
        if (!rst && bd_req_valid && !bd_req_ready && starve_cnt != SW'(STARVE_LIMIT))
          starve_d = starve_cnt + SW'(1);
        if (bd_req_ready) begin
          starve_d = '0;
          rdata_d  = '0;
          state_d  = RSP;
          if (in_range) begin
            bd_mem = 1'b1;
            err_d  = 1'b0;
            if (!bd_req_write) state_d = RD_WAIT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RD_WAIT: begin
        rdata_d = mem_rdata;
        state_d = RSP;
      end
      RSP: begin
        if (bd_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    fn_ready  = !rst && !bd_mem;
    fn_acc    = fn_valid && fn_ready;
    mem_req   = bd_mem || fn_acc;
    mem_write = fn_write;
    mem_addr  = fn_addr;
    mem_wdata = fn_wdata;
    mem_mask  = fn_mask;
    if (bd_mem) begin
      mem_write = bd_req_write;
      mem_addr  = AW'((bd_req_addr - BASE_ADDR) >> 3);
      mem_wdata = bd_req_wdata;
      mem_mask  = 8'hFF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt   <= '0;
      bd_rsp_rdata <= '0;
      bd_rsp_err   <= 1'b0;
      fn_rsp_valid <= 1'b0;
    end else begin
      starve_cnt   <= starve_d;
      bd_rsp_rdata <= rdata_d;
      bd_rsp_err   <= err_d;
      fn_rsp_valid <= fn_acc && !fn_write;
    end
  end

  assign bd_rsp_valid = (state == RSP);
  // SRAM read data is already registered; functional returns pass straight through.
  assign fn_rdata     = mem_rdata;

endmodule

// File: tb/tb_scratchpad_backdoor_responder.sv
// Directed bench for scratchpad_backdoor_responder with a small masked SRAM model.
module tb_scratchpad_backdoor_responder;

  localparam int unsigned AW = 13;

  logic          clk = 1'b0;
  logic          rst;
  logic          bd_req_valid, bd_req_ready, bd_req_write;
  logic [31:0]   bd_req_addr;
  logic [63:0]   bd_req_wdata;
  logic          bd_rsp_valid, bd_rsp_ready, bd_rsp_err;
  logic [63:0]   bd_rsp_rdata;
  logic          fn_valid, fn_ready, fn_write;
  logic [AW-1:0] fn_addr;
  logic [63:0]   fn_wdata;
  logic [7:0]    fn_mask;
  logic          fn_rsp_valid;
  logic [63:0]   fn_rdata;
  logic          mem_req, mem_write;
  logic [AW-1:0] mem_addr;
  logic [63:0]   mem_wdata;
  logic [7:0]    mem_mask;
  logic [63:0]   mem_rdata;

  logic [63:0]   mem [0:(1<<AW)-1];
  int            checks = 0;
  int            errors = 0;
  logic [AW-1:0] rd_addrs [5];
  logic [63:0]   rd_exp   [5];

  localparam logic [63:0] D2 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] D3 = 64'hCAFE_F00D_1234_5678;
  localparam logic [63:0] D4 = 64'h0000_0000_FFFF_FFFF;

  scratchpad_backdoor_responder dut (
    .clk(clk), .rst(rst),
    .bd_req_valid(bd_req_valid), .bd_req_ready(bd_req_ready), .bd_req_write(bd_req_write),
    .bd_req_addr(bd_req_addr), .bd_req_wdata(bd_req_wdata),
    .bd_rsp_valid(bd_rsp_valid), .bd_rsp_ready(bd_rsp_ready),
    .bd_rsp_rdata(bd_rsp_rdata), .bd_rsp_err(bd_rsp_err),
    .fn_valid(fn_valid), .fn_ready(fn_ready), .fn_write(fn_write), .fn_addr(fn_addr),
    .fn_wdata(fn_wdata), .fn_mask(fn_mask),
    .fn_rsp_valid(fn_rsp_valid), .fn_rdata(fn_rdata),
    .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_mask(mem_mask), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // SRAM model: byte-masked writes, registered read data.
  always @(posedge clk) begin
    if (mem_req) begin
      if (mem_write) begin
        for (int b = 0; b < 8; b++)
          if (mem_mask[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] <= '0;
    mem_rdata <= '0;
    rd_addrs = '{13'd4, 13'd2, 13'd3, 13'd4, 13'd2};
    rd_exp   = '{D4, D2, D3, D4, D2};
    rst = 1'b1;
    bd_req_valid = 1'b1; bd_req_write = 1'b0; bd_req_addr = 32'h6400_0010; bd_req_wdata = '0;
    bd_rsp_ready = 1'b1;
    fn_valid = 1'b1; fn_write = 1'b0; fn_addr = '0; fn_wdata = '0; fn_mask = 8'hFF;

    // Reset state with both requesters active
    tick();
    check("rst_bd_ready", bd_req_ready, 0);
    check("rst_fn_ready", fn_ready, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_rsp_valid", bd_rsp_valid, 0);
    check("rst_rsp_rdata", bd_rsp_rdata, 0);
    check("rst_rsp_err", bd_rsp_err, 0);
    check("rst_fn_rsp_valid", fn_rsp_valid, 0);
    rst = 1'b0; bd_req_valid = 1'b0; fn_valid = 1'b0;
    tick();

    // Backdoor write
    bd_req_valid = 1'b1; bd_req_write = 1'b1; bd_req_addr = 32'h6400_0010; bd_req_wdata = D2;
    #1;
    check("wr_bd_ready", bd_req_ready, 1);
    check("wr_mem_req", mem_req, 1);
    check("wr_mem_write", mem_write, 1);
    check("wr_mem_addr", 64'(mem_addr), 2);
    check("wr_mem_mask", mem_mask, 8'hFF);
    check("wr_mem_wdata", mem_wdata, D2);
    check("wr_fn_ready", fn_ready, 0);
    tick();
    bd_req_valid = 1'b0;
    check("wr_rsp_valid", bd_rsp_valid, 1);
    check("wr_rsp_err", bd_rsp_err, 0);
    check("wr_rsp_rdata", bd_rsp_rdata, 0);
    tick();
    check("wr_rsp_done", bd_rsp_valid, 0);

    // Backdoor read back
    bd_req_valid = 1'b1; bd_req_write = 1'b0;
    #1;
    check("rd_mem_req", mem_req, 1);
    check("rd_mem_write", mem_write, 0);
    tick();
    bd_req_valid = 1'b0;
    check("rd_wait_valid", bd_rsp_valid, 0);
    tick();
    check("rd_rsp_valid", bd_rsp_valid, 1);
    check("rd_rsp_rdata", bd_rsp_rdata, D2);
    check("rd_rsp_err", bd_rsp_err, 0);
    tick();

    // Out-of-range: past the window, then misaligned
    bd_req_valid = 1'b1; bd_req_addr = 32'h6401_0000;
    #1;
    check("oor_bd_ready", bd_req_ready, 1);
    check("oor_mem_req", mem_req, 0);
    check("oor_fn_ready", fn_ready, 1);
    tick();
    bd_req_valid = 1'b0;
    check("oor_rsp_valid", bd_rsp_valid, 1);
    check("oor_rsp_err", bd_rsp_err, 1);
    check("oor_rsp_rdata", bd_rsp_rdata, 0);
    tick();
    bd_req_valid = 1'b1; bd_req_addr = 32'h6400_0004;
    #1;
    check("mis_mem_req", mem_req, 0);
    tick();
    bd_req_valid = 1'b0;
    check("mis_rsp_valid", bd_rsp_valid, 1);
    check("mis_rsp_err", bd_rsp_err, 1);
    check("mis_rsp_rdata", bd_rsp_rdata, 0);
    tick();

    // Starvation: functional reads every cycle, backdoor wins on the 9th
    fn_valid = 1'b1; fn_write = 1'b0; fn_addr = 13'd2; fn_mask = 8'hFF;
    bd_req_valid = 1'b1; bd_req_write = 1'b1; bd_req_addr = 32'h6400_0018; bd_req_wdata = D3;
    for (int i = 1; i <= 9; i++) begin
      #1;
      check("starve_bd_ready", 64'(bd_req_ready), 64'(i == 9));
      check("starve_fn_ready", 64'(fn_ready), 64'(i != 9));
      check("starve_fn_rsp", 64'(fn_rsp_valid), 64'(i >= 2));
      if (i >= 2) check("starve_fn_rdata", fn_rdata, D2);
      if (i == 9) check("starve_mem_addr", 64'(mem_addr), 3);
      tick();
    end
    bd_req_valid = 1'b0; fn_valid = 1'b0;
    check("starve_rsp_valid", bd_rsp_valid, 1);
    check("starve_fn_denied", fn_rsp_valid, 0);
    tick();
    check("starve_rsp_done", bd_rsp_valid, 0);

    // Read with a functional masked write in RD_WAIT, then a stalled response
    bd_req_valid = 1'b1; bd_req_write = 1'b0; bd_req_addr = 32'h6400_0018;
    tick();
    bd_req_valid = 1'b0; bd_rsp_ready = 1'b0;
    fn_valid = 1'b1; fn_write = 1'b1; fn_addr = 13'd4; fn_wdata = '1; fn_mask = 8'h0F;
    #1;
    check("rdw_rsp_valid", bd_rsp_valid, 0);
    check("rdw_fn_ready", fn_ready, 1);
    check("rdw_mem_req", mem_req, 1);
    check("rdw_mem_write", mem_write, 1);
    tick();
    for (int k = 0; k < 5; k++) begin
      fn_valid = 1'b1; fn_write = 1'b0; fn_addr = rd_addrs[k]; fn_mask = 8'hFF;
      #1;
      check("hold_rsp_valid", bd_rsp_valid, 1);
      check("hold_rsp_rdata", bd_rsp_rdata, D3);
      check("hold_rsp_err", bd_rsp_err, 0);
      check("hold_fn_ready", fn_ready, 1);
      tick();
      check("hold_fn_rsp", fn_rsp_valid, 1);
      check("hold_fn_rdata", fn_rdata, rd_exp[k]);
    end
    fn_valid = 1'b0; bd_rsp_ready = 1'b1;
    #1;
    check("hold_release_valid", bd_rsp_valid, 1);
    tick();
    check("hold_done", bd_rsp_valid, 0);
    check("hold_fn_idle", fn_rsp_valid, 0);

    // Reset during RD_WAIT aborts with no response
    bd_req_valid = 1'b1; bd_req_write = 1'b0; bd_req_addr = 32'h6400_0010;
    tick();
    fn_valid = 1'b1; fn_write = 1'b0; fn_addr = 13'd2;
    #1;
    rst = 1'b1;
    #1;
    check("abort_rsp_valid", bd_rsp_valid, 0);
    check("abort_rsp_rdata", bd_rsp_rdata, 0);
    check("abort_bd_ready", bd_req_ready, 0);
    check("abort_fn_ready", fn_ready, 0);
    check("abort_mem_req", mem_req, 0);
    tick();
    check("abort_hold_valid", bd_rsp_valid, 0);
    check("abort_fn_rsp", fn_rsp_valid, 0);
    rst = 1'b0; bd_req_valid = 1'b0; fn_valid = 1'b0;
    tick();
    check("abort_after_valid", bd_rsp_valid, 0);

    // Normal traffic after reset
    bd_req_valid = 1'b1; bd_req_write = 1'b1; bd_req_addr = 32'h6400_0020;
    bd_req_wdata = 64'h55AA_1234_DEAD_BEEF;
    #1;
    check("post_bd_ready", bd_req_ready, 1);
    check("post_mem_addr", 64'(mem_addr), 4);
    tick();
    bd_req_valid = 1'b0;
    check("post_wr_valid", bd_rsp_valid, 1);
    check("post_wr_err", bd_rsp_err, 0);
    tick();
    bd_req_valid = 1'b1; bd_req_write = 1'b0;
    tick();
    bd_req_valid = 1'b0;
    tick();
    check("post_rd_valid", bd_rsp_valid, 1);
    check("post_rd_rdata", bd_rsp_rdata, 64'h55AA_1234_DEAD_BEEF);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
